// File: rtl/maxplus_pkg.sv
// Shared word width, default frame length and FSM state encoding for the maxplus frame-max block.
package maxplus_pkg;

  localparam int WORD_W      = 16;
  localparam int MAX_LEN_DEF = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/maxplus_frame_max_if.sv
// Word-in / result-out handshake bundle; slave is the frame-max block, master is its driver.
interface maxplus_frame_max_if #(
  parameter int IDX_W = 4
);
  import maxplus_pkg::*;

  word_t            in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  word_t            out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;
  logic             out_trunc;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_max, out_idx, out_count, out_trunc, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_max, out_idx, out_count, out_trunc, out_valid
  );

endinterface

// File: rtl/maxplus_cmp16.sv
// Combinational 16-bit unsigned strict greater-than; no state, no latency.
module maxplus_cmp16
  import maxplus_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  output logic  gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/maxplus_frame_max.sv
// Per-frame unsigned max/argmax/count; result valid 1 cycle after the frame-ending word and held, in_ready low, until out_ready.
// Argmax index register is built only when MAXPLUS_ARGMAX_EN is defined; otherwise out_idx is tied to 0.
module maxplus_frame_max
  import maxplus_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int IDX_W   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  maxplus_frame_max_if.slave  bus
);

  state_t         state_q, state_d;
  word_t          max_q, max_d;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic           trunc_q, trunc_d;

  logic           in_ready_c;
  logic           out_valid_c;
  logic           accept;
  logic           first;
  logic           gt;
  logic           frame_end;
  logic [IDX_W:0] cnt_nxt;

  assign accept    = bus.in_valid && in_ready_c;
  assign first     = (state_q == IDLE);
  assign cnt_nxt   = first ? (IDX_W+1)'(1) : cnt_q + (IDX_W+1)'(1);
  assign frame_end = bus.in_last || (cnt_nxt == (IDX_W+1)'(MAX_LEN));

  maxplus_cmp16 u_cmp (
    .a_i  (bus.in_data),
    .b_i  (max_q),
    .gt_o (gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = frame_end ? DONE : ACCUM;
      ACCUM:   if (accept && frame_end) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q != DONE);
    out_valid_c = (state_q == DONE);
  end

  // Running registers double as the result: nothing is accepted in DONE, so they hold.
  always_comb begin
    max_d   = max_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    if (accept) begin
      if (first || gt) max_d = bus.in_data;
      cnt_d   = cnt_nxt;
      trunc_d = frame_end && !bus.in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

`ifdef MAXPLUS_ARGMAX_EN
  logic [IDX_W-1:0] idx_q, idx_d;

  // cnt_q is below MAX_LEN in ACCUM, so it is the new word's position and never wraps.
  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      if (first)   idx_d = '0;
      else if (gt) idx_d = cnt_q[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign bus.out_idx = idx_q;
`else
  assign bus.out_idx = '0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = max_q;
  assign bus.out_count = cnt_q;
  assign bus.out_trunc = trunc_q;

endmodule
